// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch unit: default widths,
// RISC-V opcode constants and small sizing helpers.
package instr_prefetch_queue_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned ILEN_DEF         = 32;
  localparam int unsigned DEPTH_DEF        = 4;
  localparam int unsigned MAX_OUT_DEF      = 2;
  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_R    = 7'b0110011,
    OP_I    = 7'b0010011,
    OP_L    = 7'b0000011,
    OP_S    = 7'b0100011,
    OP_B    = 7'b1100011,
    OP_J    = 7'b1101111,
    OP_JALR = 7'b1100111
  } opcode_e;

  // Bits needed to hold a counter that ranges over 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// The head entry is held in its own register so the output is flop-driven.
module instr_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Next head: bypass the incoming word when it lands in the slot that
  // becomes the head, otherwise read the slot the read pointer moves to.
  always_comb begin
    rd_ptr_next = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    head_next   = (do_push && (wr_ptr == rd_ptr_next)) ? din : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_push || do_pop) begin
        head <= head_next;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetcher: issues sequential word fetches, queues returned words
// with their PCs for the decode stage, and flushes everything on a redirect.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEF,
  parameter int unsigned     ILEN            = ILEN_DEF,
  parameter int unsigned     DEPTH           = DEPTH_DEF,
  parameter int unsigned     MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF)
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [ILEN-1:0]            imem_rdata,
  output logic                       instr_valid,
  output logic [ILEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      resp_pc;
  logic [XLEN-1:0]      target_pc;
  logic [OW-1:0]        outstanding;
  logic [OW-1:0]        outstanding_next;
  logic [OW-1:0]        kill;
  logic [OW-1:0]        kill_next;
  logic [SW-1:0]        reserved;
  logic                 accept;
  logic                 resp_valid;
  logic                 push;
  logic                 pop;
  logic [XLEN+ILEN-1:0] head;

  assign target_pc  = redirect_pc & ~XLEN'(3);
  // Requests reserve queue space up front so responses can never overflow it.
  assign reserved   = SW'(q_count) + SW'(outstanding);
  assign imem_req   = !cpu_rst && !redirect && (reserved < SW'(DEPTH))
                      && (outstanding < OW'(MAX_OUTSTANDING));
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req && imem_gnt;
  assign resp_valid = imem_rvalid && (outstanding != '0);
  assign push       = resp_valid && !redirect && (kill == '0);
  assign pop        = instr_valid && instr_ready;

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !resp_valid) begin
      outstanding_next = outstanding + OW'(1);
    end else if (!accept && resp_valid) begin
      outstanding_next = outstanding - OW'(1);
    end

    kill_next = kill;
    if (redirect) begin
      // No request issues during a redirect, so every response still in
      // flight afterwards belongs to the abandoned path.
      kill_next = outstanding_next;
    end else if (resp_valid && (kill != '0)) begin
      kill_next = kill - OW'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
    end else begin
      outstanding <= outstanding_next;
      kill        <= kill_next;
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          resp_pc <= resp_pc + XLEN'(4);
        end
      end
    end
  end

  instr_fifo #(
    .WIDTH(XLEN + ILEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (cpu_clk),
    .rst  (cpu_rst),
    .flush(redirect),
    .push (push),
    .din  ({resp_pc, imem_rdata}),
    .pop  (pop),
    .head (head),
    .count(q_count)
  );

  assign instr_valid = (q_count != '0);
  assign instr       = head[ILEN-1:0];
  assign instr_pc    = head[XLEN+ILEN-1:ILEN];

  rvalid_needs_request: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a cycle-stepped memory model with
// configurable latency, a log of popped {pc, instr} pairs and hand-set expectations.
module tb_instr_prefetch_queue;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [2:0]  qcnt;

  logic        w_rst = 1'b1;
  logic        w_gnt = 1'b0;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_ready = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ivalid;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;
  logic [2:0]  w_qcnt;

  instr_prefetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
  ) dut (
    .cpu_clk(clk), .cpu_rst(rst), .imem_req(req), .imem_addr(addr), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .instr_valid(ivalid), .instr(instr),
    .instr_pc(ipc), .instr_ready(ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .q_count(qcnt)
  );

  instr_prefetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .MAX_OUTSTANDING(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut_w (
    .cpu_clk(clk), .cpu_rst(w_rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .instr_valid(w_ivalid), .instr(w_instr),
    .instr_pc(w_ipc), .instr_ready(w_ready), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .q_count(w_qcnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cn      = 0;
  int          lat     = 1;
  int          grants  = 0;
  pend_t       mq[$];
  logic [63:0] popped[$];

  logic        s_req, s_valid, sw_req;
  logic [31:0] s_addr, s_instr, s_pc, sw_addr;
  logic [2:0]  s_cnt;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  // One clock cycle: present due responses, sample at the falling edge,
  // record grants and pops, then step to just after the next rising edge.
  task automatic cyc();
    if (mq.size() > 0 && mq[0].due <= cn) begin
      rvalid = 1'b1;
      rdata  = word_of(mq[0].a);
      void'(mq.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
    #4;
    s_req   = req;
    s_addr  = addr;
    s_valid = ivalid;
    s_instr = instr;
    s_pc    = ipc;
    s_cnt   = qcnt;
    sw_req  = w_req;
    sw_addr = w_addr;
    if (req && gnt) begin
      mq.push_back('{a: addr, due: cn + lat});
      grants++;
    end
    if (ivalid && ready) popped.push_back({ipc, instr});
    @(posedge clk);
    #1;
    cn++;
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    rvalid   = 1'b0;
    gnt      = 1'b0;
    ready    = 1'b0;
    redirect = 1'b0;
    mq.delete();
    popped.delete();
    grants = 0;
    #1;
    check({tag, "_rst_req"},   req,    0);
    check({tag, "_rst_addr"},  addr,   0);
    check({tag, "_rst_valid"}, ivalid, 0);
    check({tag, "_rst_instr"}, instr,  0);
    check({tag, "_rst_pc"},    ipc,    0);
    check({tag, "_rst_cnt"},   qcnt,   0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cn  = 0;
  endtask

  task automatic expect_pop(input string tag, input int idx, input logic [31:0] pc);
    logic [63:0] e;
    e = (idx < popped.size()) ? popped[idx] : {64{1'b1}};
    check({tag, "_pc"},    e[63:32], pc);
    check({tag, "_instr"}, e[31:0],  word_of(pc));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    check("init_w_addr", w_addr, 32'hFFFF_FFF8);
    check("init_w_req",  w_req,  0);
    do_reset("init");

    // Streaming: one-cycle memory, consumer always ready.
    gnt = 1'b1; ready = 1'b1; lat = 1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      check($sformatf("t1_req%0d", n),  s_req,  1);
      check($sformatf("t1_addr%0d", n), s_addr, 4 * n);
      if (n >= 2) begin
        check($sformatf("t1_valid%0d", n), s_valid, 1);
        check($sformatf("t1_pc%0d", n),    s_pc,    4 * (n - 2));
        check($sformatf("t1_instr%0d", n), s_instr, word_of(4 * (n - 2)));
      end
    end

    // Backpressure: queue fills to DEPTH, requests stop, then drains in order.
    do_reset("t2");
    gnt = 1'b1; ready = 1'b0; lat = 1;
    repeat (8) cyc();
    check("t2_grants", grants,  4);
    check("t2_req",    s_req,   0);
    check("t2_cnt",    s_cnt,   4);
    check("t2_valid",  s_valid, 1);
    check("t2_headpc", s_pc,    0);
    ready = 1'b1;
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) expect_pop($sformatf("t2_pop%0d", i), i, 4 * i);

    // Redirect while two responses are in flight.
    do_reset("t3");
    gnt = 1'b1; ready = 1'b1; lat = 3;
    cyc();
    cyc();
    check("t3_grants", grants, 2);
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    check("t3_req_redir", s_req, 0);
    cyc();
    check("t3_cnt",   s_cnt,   0);
    check("t3_valid", s_valid, 0);
    cyc();
    check("t3_req",  s_req,  1);
    check("t3_addr", s_addr, 32'h100);
    repeat (6) cyc();
    expect_pop("t3_first", 0, 32'h100);

    // Redirect coincident with a response and a pop, unaligned target.
    do_reset("t4");
    gnt = 1'b1; ready = 1'b0; lat = 2;
    repeat (5) cyc();
    check("t4_grants", grants, 4);
    check("t4_cnt",    s_cnt,  2);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    check("t4_req_redir", s_req, 0);
    expect_pop("t4_pop", 0, 32'h0);
    cyc();
    check("t4_cnt0", s_cnt,  0);
    check("t4_req",  s_req,  1);
    check("t4_addr", s_addr, 32'h100);
    repeat (5) cyc();
    expect_pop("t4_next", 1, 32'h100);

    // Stalled grant holds the address.
    do_reset("t5");
    gnt = 1'b0; ready = 1'b1; lat = 1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      check($sformatf("t5_req%0d", n),  s_req,  1);
      check($sformatf("t5_addr%0d", n), s_addr, 0);
    end
    gnt = 1'b1;
    cyc();
    check("t5_addr_gnt", s_addr, 0);
    cyc();
    check("t5_addr_next", s_addr, 4);

    // Mid-stream reset, then restart at RESET_PC.
    ready = 1'b0;
    repeat (4) cyc();
    check("t6_filled", s_cnt != 0, 1);
    do_reset("t6_mid");
    gnt = 1'b1;
    cyc();
    check("t6_restart_req",  s_req,  1);
    check("t6_restart_addr", s_addr, 0);

    // Address wrap on the second instance.
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; mq.delete();
    w_gnt = 1'b1; w_rst = 1'b0;
    cyc();
    check("t6_w_addr0", sw_addr, 32'hFFFF_FFF8);
    check("t6_w_req0",  sw_req,  1);
    cyc();
    check("t6_w_addr1", sw_addr, 32'hFFFF_FFFC);
    cyc();
    check("t6_w_addr2", sw_addr, 32'h0000_0000);
    cyc();
    check("t6_w_addr3", sw_addr, 32'h0000_0004);
    cyc();
    check("t6_w_req_full", sw_req, 0);
    w_rst = 1'b1;
    #1;
    check("t6_w_rst_addr",  w_addr,   32'hFFFF_FFF8);
    check("t6_w_rst_req",   w_req,    0);
    check("t6_w_rst_valid", w_ivalid, 0);
    check("t6_w_rst_cnt",   w_qcnt,   0);
    @(posedge clk);
    #1;
    w_rst = 1'b0;
    cyc();
    check("t6_w_restart_req",  sw_req,  1);
    check("t6_w_restart_addr", sw_addr, 32'hFFFF_FFF8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
